// File: rtl/status_level_bar_pkg.sv
// Shared definitions for the HUD level bar: screen placement, cell colours,
// bar state encoding and the cell placement helper.
package status_level_bar_pkg;

    // Screen position of the level status object (cell 0 top-left pixel)
    localparam logic [10:0] LEVEL_STATUS_TOP_LEFT_X = 11'd40;
    localparam logic [10:0] LEVEL_STATUS_TOP_LEFT_Y = 11'd20;

    // RGB332 cell colours
    localparam logic [7:0] LEVEL_COLOR_DONE = 8'b00011100;
    localparam logic [7:0] LEVEL_COLOR_PEND = 8'b01001001;
    localparam logic [7:0] LEVEL_COLOR_FAIL = 8'b00000011;

    typedef enum logic [1:0] {
        PLAYING    = 2'd0,
        FLASH_FAIL = 2'd1,
        COMPLETE   = 2'd2
    } level_bar_state_t;

    // Left edge of cell idx; plain 11-bit unsigned sum, the parameters
    // are expected to keep the whole bar on screen.
    function automatic logic [10:0] cell_x0(input logic [10:0] x0, input int unsigned idx,
                                            input int unsigned pitch);
        return x0 + 11'(idx * pitch);
    endfunction

endpackage

// File: rtl/level_bar_cell_hit.sv
// Combinational rectangle test for one square cell of the level bar.
// A pixel hits when X0 <= x < X0+SIZE and Y0 <= y < Y0+SIZE.
module level_bar_cell_hit #(
    parameter logic [10:0] X0   = 11'd0,
    parameter logic [10:0] Y0   = 11'd0,
    parameter int unsigned SIZE = 15
) (
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        hit
);

    // Exclusive far edges kept 12 bits wide so a cell at the screen edge cannot wrap
    localparam logic [11:0] X1 = {1'b0, X0} + 12'(SIZE);
    localparam logic [11:0] Y1 = {1'b0, Y0} + 12'(SIZE);

    logic in_x;
    logic in_y;

    // Bounds comparison on both axes
    always_comb begin
        in_x = (pixel_x >= X0) && ({1'b0, pixel_x} < X1);
        in_y = (pixel_y >= Y0) && ({1'b0, pixel_y} < Y1);
        hit  = in_x && in_y;
    end

endmodule

// File: rtl/status_level_bar.sv
// Multi-level progress bar for the pinball HUD. Draws NUM_LEVELS square
// cells in a row, colours them by progress, blinks the current cell and
// flashes the whole bar after a failed level. Outputs feed the shared
// drawRequest/RGB mux and are registered (valid one clock after the pixel).
module status_level_bar
    import status_level_bar_pkg::*;
#(
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned CELL_SIZE    = 15,
    parameter int unsigned CELL_GAP     = 4,
    parameter logic [10:0] TOP_LEFT_X   = LEVEL_STATUS_TOP_LEFT_X,
    parameter logic [10:0] TOP_LEFT_Y   = LEVEL_STATUS_TOP_LEFT_Y,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned FLASH_FRAMES = 60,
    localparam int unsigned LW          = $clog2(NUM_LEVELS + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [10:0]   pixelX,
    input  logic [10:0]   pixelY,
    input  logic          startOfFrame,
    input  logic          level_up,
    input  logic          reset_level,
    input  logic          new_game,
    output logic          drawStatusLevel,
    output logic [7:0]    RGBStatusLevel,
    output logic [LW-1:0] current_level,
    output logic          all_levels_done
);

    localparam int unsigned CELL_PITCH = CELL_SIZE + CELL_GAP;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] ALL_DONE   = LW'(NUM_LEVELS);

    level_bar_state_t state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
    logic             draw_q, draw_d;
    logic [7:0]       rgb_q, rgb_d;

    logic [NUM_LEVELS-1:0] cell_hit;
    logic                  any_hit;
    logic [LW-1:0]         hit_idx;
    logic [7:0]            pix_color;

    // One comparator per cell; cells are disjoint so at most one hits
    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_cell
        level_bar_cell_hit #(
            .X0   (cell_x0(TOP_LEFT_X, i, CELL_PITCH)),
            .Y0   (TOP_LEFT_Y),
            .SIZE (CELL_SIZE)
        ) u_cell_hit (
            .pixel_x (pixelX),
            .pixel_y (pixelY),
            .hit     (cell_hit[i])
        );
    end

    // OR-based index encoder; no priority needed since hits are one-hot or zero
    always_comb begin
        any_hit = |cell_hit;
        hit_idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (cell_hit[i]) begin
                hit_idx = hit_idx | LW'(i);
            end
        end
    end

    // Cell colour from the registered state/level, so same-cycle events never affect it
    always_comb begin
        pix_color = LEVEL_COLOR_PEND;
        case (state_q)
            PLAYING: begin
                if (hit_idx < level_q) begin
                    pix_color = LEVEL_COLOR_DONE;
                end else if (hit_idx == level_q) begin
                    pix_color = blink_phase_q ? LEVEL_COLOR_DONE : LEVEL_COLOR_PEND;
                end else begin
                    pix_color = LEVEL_COLOR_PEND;
                end
            end
            FLASH_FAIL: pix_color = blink_phase_q ? LEVEL_COLOR_FAIL : LEVEL_COLOR_PEND;
            COMPLETE:   pix_color = LEVEL_COLOR_DONE;
            default:    pix_color = LEVEL_COLOR_PEND;
        endcase
    end

    // Pixel output next-state: black whenever nothing is drawn
    always_comb begin
        draw_d = any_hit;
        rgb_d  = any_hit ? pix_color : 8'h00;
    end

    // Progress FSM plus blink and flash counters
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        flash_cnt_d   = flash_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        // Blink runs in every state
        if (startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (new_game) begin
            state_d       = PLAYING;
            level_d       = '0;
            flash_cnt_d   = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            case (state_q)
                PLAYING: begin
                    if (reset_level) begin
                        state_d     = FLASH_FAIL;
                        level_d     = '0;
                        flash_cnt_d = '0;
                    end else if (level_up) begin
                        if (level_q == LAST_LEVEL) begin
                            level_d = ALL_DONE;
                            state_d = COMPLETE;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end
                end
                FLASH_FAIL: begin
                    // level_up is ignored while flashing
                    if (reset_level) begin
                        flash_cnt_d = '0;
                    end else if (startOfFrame) begin
                        if (flash_cnt_q == FLASH_LAST) begin
                            flash_cnt_d = '0;
                            state_d     = PLAYING;
                        end else begin
                            flash_cnt_d = flash_cnt_q + 1'b1;
                        end
                    end
                end
                COMPLETE: begin
                    // Sticky until new_game
                end
                default: state_d = PLAYING;
            endcase
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= PLAYING;
            level_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            flash_cnt_q   <= '0;
            draw_q        <= 1'b0;
            rgb_q         <= 8'h00;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            flash_cnt_q   <= flash_cnt_d;
            draw_q        <= draw_d;
            rgb_q         <= rgb_d;
        end
    end

    // Output drive
    always_comb begin
        drawStatusLevel = draw_q;
        RGBStatusLevel  = rgb_q;
        current_level   = level_q;
        all_levels_done = (state_q == COMPLETE);
    end

endmodule

// File: tb/tb_status_level_bar.sv
// Directed bench for status_level_bar. Pixel probes push the expected
// {draw, rgb} into a scoreboard queue; a monitor pops and compares one
// clock later. Level/done outputs are checked directly after each event.
module tb_status_level_bar;

    localparam logic [7:0] C_DONE = 8'b00011100;
    localparam logic [7:0] C_PEND = 8'b01001001;
    localparam logic [7:0] C_FAIL = 8'b00000011;

    // Cell i left edge = 40 + 19*i: 40, 59, 78, 97; rows 20..34
    localparam int X0 = 40;
    localparam int Y0 = 20;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        level_up;
    logic        reset_level;
    logic        new_game;
    logic        drawStatusLevel;
    logic [7:0]  RGBStatusLevel;
    logic [2:0]  current_level;
    logic        all_levels_done;

    int total = 0;
    int bad   = 0;

    logic       probe_req = 1'b0;
    logic       chk_pipe  = 1'b0;
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] mon_exp;
    string      mon_name;

    status_level_bar #(
        .NUM_LEVELS   (4),
        .CELL_SIZE    (15),
        .CELL_GAP     (4),
        .TOP_LEFT_X   (11'd40),
        .TOP_LEFT_Y   (11'd20),
        .BLINK_FRAMES (16),
        .FLASH_FRAMES (60)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .level_up        (level_up),
        .reset_level     (reset_level),
        .new_game        (new_game),
        .drawStatusLevel (drawStatusLevel),
        .RGBStatusLevel  (RGBStatusLevel),
        .current_level   (current_level),
        .all_levels_done (all_levels_done)
    );

    always #5 clk = ~clk;

    // Marks the cycle whose registered output belongs to a probe
    always @(posedge clk) chk_pipe <= probe_req;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (chk_pipe) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: output presented with no expectation queued");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if ({drawStatusLevel, RGBStatusLevel} !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got draw=%b rgb=%b want draw=%b rgb=%b", mon_name,
                             drawStatusLevel, RGBStatusLevel, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic probe(input int x, input int y, input logic d, input logic [7:0] c,
                         input string nm);
        @(negedge clk);
        pixelX    = 11'(x);
        pixelY    = 11'(y);
        probe_req = 1'b1;
        exp_q.push_back({d, c});
        name_q.push_back(nm);
        @(negedge clk);
        probe_req = 1'b0;
        pixelX    = 11'd0;
        pixelY    = 11'd0;
    endtask

    task automatic pulse(input logic lu, input logic rl, input logic ng);
        @(negedge clk);
        level_up    = lu;
        reset_level = rl;
        new_game    = ng;
        @(negedge clk);
        level_up    = 1'b0;
        reset_level = 1'b0;
        new_game    = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    // Reset held one cycle with a cell pixel presented, so draw would be 1 otherwise
    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b1;
        pixelX = 11'(X0 + 19);
        pixelY = 11'(Y0);
        @(negedge clk);
        resetN = 1'b0;
        pixelX = 11'd0;
        pixelY = 11'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN       = 1'b1;
        pixelX       = 11'(X0);
        pixelY       = 11'(Y0);
        startOfFrame = 1'b0;
        level_up     = 1'b0;
        reset_level  = 1'b0;
        new_game     = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        chk("reset draw", 32'(drawStatusLevel), 0);
        chk("reset rgb", 32'(RGBStatusLevel), 0);
        chk("reset level", 32'(current_level), 0);
        chk("reset done", 32'(all_levels_done), 0);

        // Level 0, phase 0: current cell shows PEND; after 16 frames phase 1 shows DONE
        probe(X0, Y0, 1'b1, C_PEND, "cell0 phase0");
        frames(16);
        probe(X0, Y0, 1'b1, C_DONE, "cell0 phase1");
        probe(X0 + 19, Y0, 1'b1, C_PEND, "cell1 pending");

        // Two level_up -> level 2 (phase 1)
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level after 2 ups", 32'(current_level), 2);
        probe(X0 + 3, Y0 + 14, 1'b1, C_DONE, "cell0 done");
        probe(X0 + 19, Y0, 1'b1, C_DONE, "cell1 done");
        probe(X0 + 38, Y0 + 14, 1'b1, C_DONE, "cell2 current blink on");
        probe(X0 + 71, Y0 + 5, 1'b1, C_PEND, "cell3 right edge pending");
        probe(X0 + 15, Y0, 1'b0, 8'h00, "first gap column");
        probe(X0 + 18, Y0, 1'b0, 8'h00, "last gap column");
        probe(X0, Y0 + 15, 1'b0, 8'h00, "row below");
        probe(X0, Y0 - 1, 1'b0, 8'h00, "row above");
        probe(X0 + 72, Y0, 1'b0, 8'h00, "past last cell");

        // reset_level at level 2 -> FLASH_FAIL, level 0; phase still 1
        pulse(1'b0, 1'b1, 1'b0);
        chk("level after fail", 32'(current_level), 0);
        probe(X0, Y0, 1'b1, C_FAIL, "flash cell0 on");
        probe(X0 + 57, Y0, 1'b1, C_FAIL, "flash cell3 on");
        frames(16);
        probe(X0, Y0, 1'b1, C_PEND, "flash cell0 off");
        frames(16);
        probe(X0 + 38, Y0, 1'b1, C_FAIL, "flash cell2 on");
        frames(27);
        // 59 frames into the flash: still flashing, level_up ignored
        pulse(1'b1, 1'b0, 1'b0);
        chk("level_up ignored in flash", 32'(current_level), 0);
        frames(1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level_up after flash end", 32'(current_level), 1);
        probe(X0, Y0, 1'b1, C_DONE, "post flash cell0");
        probe(X0 + 19, Y0, 1'b1, C_PEND, "post flash cell1 phase0");

        // Priority: reset_level beats level_up; new_game beats reset_level
        pulse(1'b1, 1'b1, 1'b0);
        chk("reset_level over level_up", 32'(current_level), 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("flash entered by priority", 32'(current_level), 0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("new_game level", 32'(current_level), 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("new_game back to playing", 32'(current_level), 1);
        probe(X0 + 19, Y0, 1'b1, C_PEND, "new_game blink cleared");
        probe(X0, Y0, 1'b1, C_DONE, "new_game cell0 done");

        // Complete the bar
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level 3", 32'(current_level), 3);
        chk("not done at 3", 32'(all_levels_done), 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level complete", 32'(current_level), 4);
        chk("done set", 32'(all_levels_done), 1);
        probe(X0 + 57, Y0, 1'b1, C_DONE, "complete cell3");
        probe(X0, Y0, 1'b1, C_DONE, "complete cell0");
        pulse(1'b0, 1'b1, 1'b0);
        chk("reset_level ignored in complete", 32'(current_level), 4);
        chk("done sticky", 32'(all_levels_done), 1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level_up ignored in complete", 32'(current_level), 4);

        // Reset in the middle of a flash
        pulse(1'b0, 1'b0, 1'b1);
        chk("new_game clears done", 32'(all_levels_done), 0);
        pulse(1'b0, 1'b1, 1'b0);
        frames(16);
        probe(X0 + 19, Y0, 1'b1, C_FAIL, "flash before reset");
        do_reset();
        chk("mid-flash reset draw", 32'(drawStatusLevel), 0);
        chk("mid-flash reset rgb", 32'(RGBStatusLevel), 0);
        chk("mid-flash reset level", 32'(current_level), 0);
        chk("mid-flash reset done", 32'(all_levels_done), 0);
        probe(X0, Y0, 1'b1, C_PEND, "after reset phase0");
        pulse(1'b1, 1'b0, 1'b0);
        chk("playing after reset", 32'(current_level), 1);
        frames(15);
        probe(X0 + 19, Y0, 1'b1, C_PEND, "blink count cleared by reset");
        frames(1);
        probe(X0 + 19, Y0, 1'b1, C_DONE, "blink wraps after 16");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_level_bar.md
Name: status_level_bar

Overview:
Parametrised multi-level progress indicator for the pinball HUD. It draws NUM_LEVELS square cells in a horizontal row and colours each cell by game progress. The current cell blinks, and a level reset flashes the whole bar. It feeds the same drawRequest/RGB mux as the other status objects and replaces the single-square level status.

Parameters:
NUM_LEVELS, 4, number of cells/levels (1..16)
CELL_SIZE, 15, cell width and height in pixels
CELL_GAP, 4, horizontal gap between adjacent cells in pixels
TOP_LEFT_X, LEVEL_STATUS_TOP_LEFT_X, x of cell 0's top-left pixel
TOP_LEFT_Y, LEVEL_STATUS_TOP_LEFT_Y, y of cell 0's top-left pixel
BLINK_FRAMES, 16, frames per blink half-period of the current cell (>=1)
FLASH_FRAMES, 60, duration of the failure flash in frames (>=1)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous, active-high reset
pixelX  in  11  current scan x
pixelY  in  11  current scan y
startOfFrame  in  1  one-cycle pulse per video frame
level_up  in  1  one-cycle pulse: current level completed
reset_level  in  1  one-cycle pulse: level failed, progress lost
new_game  in  1  one-cycle pulse: restart from level 0
drawStatusLevel  out  1  pixel lies inside any cell (registered)
RGBStatusLevel  out  8  RGB332 colour of that pixel (registered)
current_level  out  LW  index of the active level, LW = $clog2(NUM_LEVELS+1)
all_levels_done  out  1  high while in COMPLETE

Behaviour:
- Reset (resetN=1 at a clk edge): state=PLAYING, current_level=0, blink_cnt=0, blink_phase=0, flash_cnt=0, drawStatusLevel=0, RGBStatusLevel=8'h00, all_levels_done=0.
- States:
  - PLAYING
  - FLASH_FAIL
  - COMPLETE
- Event priority within one cycle: new_game > reset_level > level_up.
- PLAYING:
  - level_up with current_level<NUM_LEVELS-1: current_level+1.
  - level_up with current_level==NUM_LEVELS-1: current_level=NUM_LEVELS, go to COMPLETE.
  - reset_level: current_level=0, flash_cnt=0, go to FLASH_FAIL.
- FLASH_FAIL:
  - level_up is ignored.
  - flash_cnt increments on each startOfFrame.
  - When flash_cnt reaches FLASH_FRAMES-1 and startOfFrame arrives, return to PLAYING.
  - reset_level restarts flash_cnt at 0.
- COMPLETE: sticky. level_up and reset_level are ignored; all_levels_done=1.
- new_game (any state): current_level=0, blink and flash counters cleared, go to PLAYING.
- Blink:
  - blink_cnt counts startOfFrame pulses modulo BLINK_FRAMES.
  - blink_phase toggles when blink_cnt wraps.
  - The blink logic runs in every state.
- Hit test:
  - Cell i spans x in [TOP_LEFT_X + i*(CELL_SIZE+CELL_GAP), +CELL_SIZE) and y in [TOP_LEFT_Y, +CELL_SIZE).
  - Bounds are compared with >= and <, so each cell is exactly CELL_SIZE pixels wide and tall.
  - Implement as one generate-loop comparator per cell. No divider.
  - Gaps and out-of-range pixels give draw=0.
- Colour of the hit cell i:
  - PLAYING: i<current_level gives DONE (8'b00011100). i==current_level gives DONE if blink_phase=1, else PEND. i>current_level gives PEND (8'b01001001).
  - FLASH_FAIL: all cells FAIL (8'b00000011) if blink_phase=1, else PEND.
  - COMPLETE: all cells DONE.
- Latency: drawStatusLevel and RGBStatusLevel are registered, so they are valid 1 clk after pixelX/pixelY. RGBStatusLevel=8'h00 whenever draw=0.
- The colour for a pixel uses the state and level held before any event arriving in that same cycle.
- Widths: cell x-offset arithmetic is 11-bit, unsigned, with no wrap; parameters must keep the bar on screen.

Decomposition:
- defines package:
  - LEVEL_STATUS_TOP_LEFT_X/Y (existing)
  - new LEVEL_COLOR_DONE, LEVEL_COLOR_PEND, LEVEL_COLOR_FAIL constants
  - level_bar_state_t enum {PLAYING, FLASH_FAIL, COMPLETE}
- One sub-module, level_bar_cell_hit: a combinational per-cell rectangle test. Parameters: X0, Y0, SIZE. Output: hit.
- The top level instantiates NUM_LEVELS copies and a priority-free OR/index encoder, since cells are disjoint.

Test Plan:
- Reset, then scan pixel (TOP_LEFT_X, TOP_LEFT_Y) -> 1 clk later draw=1, RGB=DONE or PEND per blink_phase; current_level=0.
- Two level_up pulses -> current_level=2. Pixels in cells 0 and 1 give 8'b00011100, cell 3 gives 8'b01001001. Pixel at x=TOP_LEFT_X+CELL_SIZE (first gap column) gives draw=0.
- Four level_up pulses with NUM_LEVELS=4 -> current_level=4, all_levels_done=1. Further reset_level is ignored.
- reset_level at level 2 -> current_level=0, FLASH_FAIL. Cells alternate 8'b00000011/PEND every 16 frames. After 60 startOfFrame pulses, back to PLAYING.
- level_up and reset_level in the same cycle at level 1 -> current_level=0, FLASH_FAIL. new_game plus reset_level -> PLAYING, level 0.
- resetN asserted mid-FLASH_FAIL -> next cycle PLAYING, draw=0, RGB=8'h00, counters cleared.
